// File: rtl/vx_wb_commit_sink.sv
// ---------------------------------------------------------------------------
// vx_wb_commit_sink
//
// Consumer end of the writeback interface. Incoming writeback transfers are
// buffered in a 2-entry skid FIFO whose head drives the GPR bank write port.
// The block also owns the per-warp register in-use scoreboard: an issued
// instruction that writes rd marks inuse[wid][rd]; the final (eop) writeback
// of that instruction releases it. Issue-side hazard checks read the
// scoreboard to produce o_ib_ready.
//
// Optional feature (macro SCOREBOARD_BYPASS_EN):
//   defined   - o_ib_ready also asserts for a busy (wid,rd) that is being
//               released by the FIFO head in this same cycle.
//   undefined - o_ib_ready is purely the registered in-use bit.
//
// Ports:
//   i_clk, i_reset           clock, synchronous active-low reset
//   i_wb_*, o_wb_ready       writeback transfer in (valid/ready)
//   i_ib_*, o_ib_ready       issue candidate hazard check
//   o_gpr_*, i_gpr_wready    GPR bank write port
//   o_busy                   FIFO non-empty or any in-use bit set
//   o_dbg_count              FIFO occupancy (debug)
//   o_dbg_head_pc            PC of the FIFO head (trace/debug)
//
// Handshake: a transfer on i_wb_* happens on a rising edge where both
// i_wb_valid and o_wb_ready are 1. o_wb_ready is registered and reflects
// whether the FIFO had a free slot after the previous edge, so the source
// never sees a combinational path from the write port.
// ---------------------------------------------------------------------------
module vx_wb_commit_sink #(
    parameter int NUM_WARPS   = 4,
    parameter int NUM_THREADS = 4,
    parameter int NUM_REGS    = 64,
    parameter int NW_BITS     = $clog2(NUM_WARPS),
    parameter int NR_BITS     = $clog2(NUM_REGS)
) (
    input  logic                       i_clk,
    input  logic                       i_reset,

    input  logic                       i_wb_valid,
    input  logic [NW_BITS-1:0]         i_wb_wid,
    input  logic [31:0]                i_wb_PC,
    input  logic [NUM_THREADS-1:0]     i_wb_tmask,
    input  logic [NR_BITS-1:0]         i_wb_rd,
    input  logic [NUM_THREADS*32-1:0]  i_wb_data,
    input  logic                       i_wb_eop,
    output logic                       o_wb_ready,

    input  logic                       i_ib_valid,
    input  logic [NW_BITS-1:0]         i_ib_wid,
    input  logic [NR_BITS-1:0]         i_ib_rd,
    input  logic                       i_ib_wb,
    output logic                       o_ib_ready,

    output logic [NUM_THREADS-1:0]     o_gpr_we,
    output logic [NW_BITS-1:0]         o_gpr_wid,
    output logic [NR_BITS-1:0]         o_gpr_waddr,
    output logic [NUM_THREADS*32-1:0]  o_gpr_wdata,
    input  logic                       i_gpr_wready,

    output logic                       o_busy,
    output logic [1:0]                 o_dbg_count,
    output logic [31:0]                o_dbg_head_pc
);

    // FIFO storage (two entries, 1-bit wrapping pointers)
    logic [NW_BITS-1:0]        r_fifo_wid   [2];
    logic [31:0]               r_fifo_pc    [2];
    logic [NUM_THREADS-1:0]    r_fifo_tmask [2];
    logic [NR_BITS-1:0]        r_fifo_rd    [2];
    logic [NUM_THREADS*32-1:0] r_fifo_data  [2];
    logic                      r_fifo_eop   [2];

    logic       r_wptr;
    logic       r_rptr;
    logic [1:0] r_count;
    logic       r_wb_ready;

    logic [NUM_WARPS-1:0][NUM_REGS-1:0] r_inuse;

    logic                      w_push;
    logic                      w_pop;
    logic                      w_head_valid;
    logic [NW_BITS-1:0]        w_head_wid;
    logic [NR_BITS-1:0]        w_head_rd;
    logic [NUM_THREADS-1:0]    w_head_tmask;
    logic                      w_head_eop;
    logic [1:0]                w_count_next;
    logic                      w_release;
    logic                      w_set;
    logic                      w_ib_busy;
    logic                      w_bypass_hit;

    // -----------------------------------------------------------------------
    // Head of the FIFO
    // -----------------------------------------------------------------------
    assign w_head_valid = (r_count != 2'd0);
    assign w_head_wid   = r_fifo_wid[r_rptr];
    assign w_head_rd    = r_fifo_rd[r_rptr];
    assign w_head_tmask = r_fifo_tmask[r_rptr];
    assign w_head_eop   = r_fifo_eop[r_rptr];

    // rd==0 is never written, so such an entry drains without waiting for
    // the bank write port.
    assign w_push = i_wb_valid && r_wb_ready;
    assign w_pop  = w_head_valid && (i_gpr_wready || (w_head_rd == '0));

    assign o_gpr_we    = (w_head_valid && (w_head_rd != '0)) ? w_head_tmask : '0;
    assign o_gpr_wid   = w_head_wid;
    assign o_gpr_waddr = w_head_rd;
    assign o_gpr_wdata = r_fifo_data[r_rptr];

    always_comb begin
        w_count_next = r_count;
        case ({w_push, w_pop})
            2'b10:   w_count_next = r_count + 2'd1;
            2'b01:   w_count_next = r_count - 2'd1;
            default: w_count_next = r_count;
        endcase
    end

    // -----------------------------------------------------------------------
    // Scoreboard hazard check
    // -----------------------------------------------------------------------
    assign w_release    = w_pop && w_head_eop;
    assign w_ib_busy    = i_ib_wb && r_inuse[i_ib_wid][i_ib_rd];
    assign w_bypass_hit = w_release && (w_head_wid == i_ib_wid) && (w_head_rd == i_ib_rd);

`ifdef SCOREBOARD_BYPASS_EN
    // The bit being released this cycle is re-claimed by the new issue.
    assign o_ib_ready = !w_ib_busy || w_bypass_hit;
`else
    assign o_ib_ready = !w_ib_busy;
`endif

    assign w_set = i_ib_valid && o_ib_ready && i_ib_wb && (i_ib_rd != '0);

    // -----------------------------------------------------------------------
    // Control state
    // -----------------------------------------------------------------------
    always_ff @(posedge i_clk) begin
        if (!i_reset) begin
            r_wptr     <= 1'b0;
            r_rptr     <= 1'b0;
            r_count    <= 2'd0;
            r_wb_ready <= 1'b1;
            r_inuse    <= '0;
        end else begin
            if (w_push) r_wptr <= ~r_wptr;
            if (w_pop)  r_rptr <= ~r_rptr;
            r_count    <= w_count_next;
            r_wb_ready <= (w_count_next != 2'd2);
            // Clear first so a same-edge set of the same bit wins.
            if (w_release) r_inuse[w_head_wid][w_head_rd] <= 1'b0;
            if (w_set)     r_inuse[i_ib_wid][i_ib_rd]     <= 1'b1;
        end
    end

    // FIFO payload needs no reset: r_count gates every use of it.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_wid[r_wptr]   <= i_wb_wid;
            r_fifo_pc[r_wptr]    <= i_wb_PC;
            r_fifo_tmask[r_wptr] <= i_wb_tmask;
            r_fifo_rd[r_wptr]    <= i_wb_rd;
            r_fifo_data[r_wptr]  <= i_wb_data;
            r_fifo_eop[r_wptr]   <= i_wb_eop;
        end
    end

    assign o_wb_ready    = r_wb_ready;
    assign o_busy        = (r_count != 2'd0) || (|r_inuse);
    assign o_dbg_count   = r_count;
    assign o_dbg_head_pc = r_fifo_pc[r_rptr];

endmodule

// File: tb/tb_vx_wb_commit_sink.sv
// Bench for vx_wb_commit_sink: directed vectors, expected GPR writes queued
// by the stimulus and checked by an independent write-port monitor.
module tb_vx_wb_commit_sink;

`ifdef SCOREBOARD_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    logic         clk;
    logic         i_reset;
    logic         i_wb_valid;
    logic [1:0]   i_wb_wid;
    logic [31:0]  i_wb_PC;
    logic [3:0]   i_wb_tmask;
    logic [5:0]   i_wb_rd;
    logic [127:0] i_wb_data;
    logic         i_wb_eop;
    logic         o_wb_ready;
    logic         i_ib_valid;
    logic [1:0]   i_ib_wid;
    logic [5:0]   i_ib_rd;
    logic         i_ib_wb;
    logic         o_ib_ready;
    logic [3:0]   o_gpr_we;
    logic [1:0]   o_gpr_wid;
    logic [5:0]   o_gpr_waddr;
    logic [127:0] o_gpr_wdata;
    logic         i_gpr_wready;
    logic         o_busy;
    logic [1:0]   o_dbg_count;
    logic [31:0]  o_dbg_head_pc;

    vx_wb_commit_sink dut (
        .i_clk(clk), .i_reset(i_reset),
        .i_wb_valid(i_wb_valid), .i_wb_wid(i_wb_wid), .i_wb_PC(i_wb_PC),
        .i_wb_tmask(i_wb_tmask), .i_wb_rd(i_wb_rd), .i_wb_data(i_wb_data),
        .i_wb_eop(i_wb_eop), .o_wb_ready(o_wb_ready),
        .i_ib_valid(i_ib_valid), .i_ib_wid(i_ib_wid), .i_ib_rd(i_ib_rd),
        .i_ib_wb(i_ib_wb), .o_ib_ready(o_ib_ready),
        .o_gpr_we(o_gpr_we), .o_gpr_wid(o_gpr_wid), .o_gpr_waddr(o_gpr_waddr),
        .o_gpr_wdata(o_gpr_wdata), .i_gpr_wready(i_gpr_wready),
        .o_busy(o_busy), .o_dbg_count(o_dbg_count), .o_dbg_head_pc(o_dbg_head_pc)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: got no end of test, expected finish before 200000");
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [1:0]   wid;
        logic [5:0]   rd;
        logic [3:0]   tmask;
        logic [127:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_tests = 0;
    int  n_fail  = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a write happens when the head is enabled and the port is free.
    always @(negedge clk) begin
        if (i_reset && (o_gpr_we != 4'b0) && i_gpr_wready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL gpr_unexpected_write: got waddr %0d, expected no write", o_gpr_waddr);
            end else begin
                mon_e = exp_q.pop_front();
                chk("gpr_we",    {124'b0, o_gpr_we},    {124'b0, mon_e.tmask});
                chk("gpr_wid",   {126'b0, o_gpr_wid},   {126'b0, mon_e.wid});
                chk("gpr_waddr", {122'b0, o_gpr_waddr}, {122'b0, mon_e.rd});
                chk("gpr_wdata", o_gpr_wdata, mon_e.data);
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic wb_send(input logic [1:0] wid, input logic [5:0] rd, input logic [3:0] tm,
                           input logic [127:0] d, input logic eop);
        bit acc;
        int n;
        i_wb_valid = 1'b1;
        i_wb_wid   = wid;
        i_wb_rd    = rd;
        i_wb_tmask = tm;
        i_wb_data  = d;
        i_wb_eop   = eop;
        i_wb_PC    = 32'h8000_0000 | {26'b0, rd};
        if (rd != 6'd0) exp_q.push_back('{wid, rd, tm, d});
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 20) begin
            @(negedge clk);
            acc = o_wb_ready;
            @(posedge clk);
            #1;
            n++;
        end
        if (!acc) begin
            n_tests++;
            n_fail++;
            $display("FAIL wb_accept_timeout: got wb_ready=0 for %0d cycles, expected accept", n);
        end
        i_wb_valid = 1'b0;
    endtask

    // One-cycle issue pulse; candidate fields stay driven for later checks.
    task automatic issue(input logic [1:0] wid, input logic [5:0] rd);
        i_ib_valid = 1'b1;
        i_ib_wid   = wid;
        i_ib_rd    = rd;
        i_ib_wb    = 1'b1;
        @(posedge clk);
        #1;
        i_ib_valid = 1'b0;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    localparam logic [127:0] LANES_1234 = {32'd4, 32'd3, 32'd2, 32'd1};

    // ---------------- directed sequence ----------------
    initial begin
        i_reset = 1'b0; i_wb_valid = 1'b0; i_wb_wid = '0; i_wb_PC = '0;
        i_wb_tmask = '0; i_wb_rd = '0; i_wb_data = '0; i_wb_eop = 1'b0;
        i_ib_valid = 1'b0; i_ib_wid = '0; i_ib_rd = '0; i_ib_wb = 1'b0;
        i_gpr_wready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        i_reset = 1'b1;

        // Reset / idle
        i_ib_wid = 2'd1; i_ib_rd = 6'd5; i_ib_wb = 1'b1;
        @(negedge clk);
        chk("reset_wb_ready", {127'b0, o_wb_ready}, 128'd1);
        chk("reset_ib_ready", {127'b0, o_ib_ready}, 128'd1);
        chk("reset_gpr_we",   {124'b0, o_gpr_we},   128'd0);
        chk("reset_busy",     {127'b0, o_busy},     128'd0);

        // Issue wid1 rd5, hazard, then eop writeback releases it
        step();
        issue(2'd1, 6'd5);
        @(negedge clk);
        chk("hazard_ib_ready", {127'b0, o_ib_ready}, 128'd0);
        chk("hazard_busy",     {127'b0, o_busy},     128'd1);
        step();
        wb_send(2'd1, 6'd5, 4'b1011, LANES_1234, 1'b1);
        @(negedge clk);
        chk("latency_gpr_we",   {124'b0, o_gpr_we},  {124'b0, 4'b1011});
        chk("pop_cycle_ib_ready", {127'b0, o_ib_ready}, {127'b0, BYP});
        chk("head_pc",          {96'b0, o_dbg_head_pc}, {96'b0, 32'h8000_0005});
        step();
        @(negedge clk);
        chk("release_ib_ready", {127'b0, o_ib_ready}, 128'd1);
        chk("release_busy",     {127'b0, o_busy},     128'd0);

        // Backpressure: write port stalled, FIFO fills, third waits
        step();
        i_gpr_wready = 1'b0;
        wb_send(2'd0, 6'd10, 4'b0001, 128'hA0A, 1'b0);
        wb_send(2'd1, 6'd11, 4'b0010, 128'hB0B, 1'b0);
        @(negedge clk);
        chk("full_wb_ready", {127'b0, o_wb_ready},  128'd0);
        chk("full_count",    {126'b0, o_dbg_count}, 128'd2);
        chk("stall_head",    {122'b0, o_gpr_waddr}, 128'd10);
        i_wb_valid = 1'b1; i_wb_rd = 6'd12;
        step();
        @(negedge clk);
        chk("stall_wb_ready", {127'b0, o_wb_ready},  128'd0);
        chk("stall_count",    {126'b0, o_dbg_count}, 128'd2);
        step();
        i_gpr_wready = 1'b1;
        wb_send(2'd2, 6'd12, 4'b1100, 128'hC0C, 1'b0);
        @(negedge clk);
        chk("skid_count", {126'b0, o_dbg_count}, 128'd1);
        step();
        @(negedge clk);
        chk("drain_busy", {127'b0, o_busy}, 128'd0);

        // Multi-packet instruction: only eop releases
        step();
        issue(2'd0, 6'd7);
        wb_send(2'd0, 6'd7, 4'b1111, 128'h7, 1'b0);
        @(negedge clk);
        chk("nonEop_pop_ib_ready", {127'b0, o_ib_ready}, 128'd0);
        step();
        @(negedge clk);
        chk("after_nonEop_ib_ready", {127'b0, o_ib_ready}, 128'd0);
        chk("after_nonEop_busy",     {127'b0, o_busy},     128'd1);
        step();
        wb_send(2'd0, 6'd7, 4'b0110, 128'h77, 1'b1);
        step();
        @(negedge clk);
        chk("after_eop_ib_ready", {127'b0, o_ib_ready}, 128'd1);
        chk("after_eop_busy",     {127'b0, o_busy},     128'd0);

        // rd == 0: no write, drains immediately, never blocks
        step();
        i_gpr_wready = 1'b0;
        wb_send(2'd3, 6'd0, 4'b1111, 128'hDEAD, 1'b1);
        @(negedge clk);
        chk("rd0_gpr_we", {124'b0, o_gpr_we},    128'd0);
        chk("rd0_count",  {126'b0, o_dbg_count}, 128'd1);
        step();
        @(negedge clk);
        chk("rd0_drained", {126'b0, o_dbg_count}, 128'd0);
        i_gpr_wready = 1'b1;
        i_ib_valid = 1'b1; i_ib_wid = 2'd3; i_ib_rd = 6'd0; i_ib_wb = 1'b1;
        @(negedge clk);
        chk("rd0_ib_ready", {127'b0, o_ib_ready}, 128'd1);
        step();
        i_ib_valid = 1'b0;
        @(negedge clk);
        chk("rd0_no_set_busy", {127'b0, o_busy}, 128'd0);

        // Same-cycle release and re-issue of wid2 rd9
        step();
        issue(2'd2, 6'd9);
        wb_send(2'd2, 6'd9, 4'b0101, 128'h99, 1'b1);
        i_ib_valid = 1'b1; i_ib_wid = 2'd2; i_ib_rd = 6'd9; i_ib_wb = 1'b1;
        @(negedge clk);
        chk("bypass_ib_ready", {127'b0, o_ib_ready}, {127'b0, BYP});
        step();
        i_ib_valid = 1'b0;
        @(negedge clk);
        chk("bypass_busy",     {127'b0, o_busy},     {127'b0, BYP});
        chk("bypass_inuse",    {127'b0, o_ib_ready}, {127'b0, !BYP});
        step();
        wb_send(2'd2, 6'd9, 4'b1000, 128'h999, 1'b1);
        step();
        @(negedge clk);
        chk("bypass_cleanup_busy", {127'b0, o_busy}, 128'd0);

        // Reset while entries are buffered and a register is in use
        step();
        issue(2'd3, 6'd12);
        i_gpr_wready = 1'b0;
        wb_send(2'd3, 6'd12, 4'b0011, 128'h55, 1'b1);
        wb_send(2'd3, 6'd13, 4'b0011, 128'h66, 1'b1);
        i_reset = 1'b0;
        exp_q.delete();
        step();
        i_reset = 1'b1;
        i_gpr_wready = 1'b1;
        @(negedge clk);
        chk("midreset_busy",     {127'b0, o_busy},      128'd0);
        chk("midreset_gpr_we",   {124'b0, o_gpr_we},    128'd0);
        chk("midreset_wb_ready", {127'b0, o_wb_ready},  128'd1);
        chk("midreset_ib_ready", {127'b0, o_ib_ready},  128'd1);
        repeat (3) step();

        @(negedge clk);
        chk("exp_q_empty", exp_q.size(), 128'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
